// File: rtl/inertial_and_filter.sv
// Clocked inertial-delay AND gate: out follows in0 & in1 only after the new
// level has held for DELAY edges; shorter pulses are rejected and counted.
module inertial_and_filter #(
    parameter int DELAY = 10,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0,
    input  logic             in1,
    output logic             out,
    output logic             pending,
    output logic             glitch,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam logic [0:0] STABLE  = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;
    localparam logic [7:0] DELAY_T = 8'(DELAY);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       a;
    logic [0:0] state;
    logic       target;
    logic [7:0] timer;

    assign a = in0 & in1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= STABLE;
            target     <= 1'b0;
            timer      <= 8'd0;
            out        <= 1'b0;
            pending    <= 1'b0;
            glitch     <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            glitch <= 1'b0;
            case (state)
                STABLE: begin
                    if (a != out) begin
                        state   <= PENDING;
                        target  <= a;
                        timer   <= 8'd1;
                        pending <= 1'b1;
                    end
                end
                default: begin
                    if (a == target) begin
                        // timer already counts e0 as 1, so commit lands on e0+DELAY
                        if (timer == DELAY_T) begin
                            out     <= target;
                            state   <= STABLE;
                            pending <= 1'b0;
                            timer   <= 8'd0;
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end else begin
                        glitch     <= 1'b1;
                        glitch_cnt <= sat_inc(glitch_cnt);
                        state      <= STABLE;
                        pending    <= 1'b0;
                        timer      <= 8'd0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inertial_and_filter.sv
// Directed bench for inertial_and_filter with DELAY=4 and a 2-bit glitch counter.
module tb_inertial_and_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic       in0;
    logic       in1;
    logic       out;
    logic       pending;
    logic       glitch;
    logic [1:0] glitch_cnt;

    int total = 0;
    int passed = 0;

    inertial_and_filter #(.DELAY(4), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in0        (in0),
        .in1        (in1),
        .out        (out),
        .pending    (pending),
        .glitch     (glitch),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        // Reset held with a=1: outputs must stay cleared
        rst = 1'b1; in0 = 1'b1; in1 = 1'b1;
        tick(); tick();
        chk("rst_out", 8'(out), 8'd0);
        chk("rst_pending", 8'(pending), 8'd0);
        chk("rst_glitch", 8'(glitch), 8'd0);
        chk("rst_cnt", 8'(glitch_cnt), 8'd0);

        // Clean rise: e0 is the first edge after release
        rst = 1'b0;
        tick();
        chk("rise_pending_e0", 8'(pending), 8'd1);
        chk("rise_out_e0", 8'(out), 8'd0);
        tick(); tick(); tick();
        chk("rise_out_e3", 8'(out), 8'd0);
        chk("rise_pending_e3", 8'(pending), 8'd1);
        tick();
        chk("rise_out_e4", 8'(out), 8'd1);
        chk("rise_pending_e4", 8'(pending), 8'd0);
        chk("rise_glitch_e4", 8'(glitch), 8'd0);

        // One-cycle falling glitch while out=1
        in1 = 1'b0;
        tick();
        chk("fall_pending", 8'(pending), 8'd1);
        in1 = 1'b1;
        tick();
        chk("fall_glitch", 8'(glitch), 8'd1);
        chk("fall_cnt", 8'(glitch_cnt), 8'd1);
        chk("fall_out", 8'(out), 8'd1);
        chk("fall_pending_clr", 8'(pending), 8'd0);
        tick();
        chk("fall_glitch_clr", 8'(glitch), 8'd0);

        // Sustained drop reaches out at e0+4
        in1 = 1'b0;
        tick(); tick(); tick(); tick();
        chk("drop_out_e3", 8'(out), 8'd1);
        tick();
        chk("drop_out_e4", 8'(out), 8'd0);
        chk("drop_pending_e4", 8'(pending), 8'd0);
        chk("drop_cnt", 8'(glitch_cnt), 8'd1);

        // Short pulse: a=1 for e0..e0+2, rejected at e0+3
        rst = 1'b1; in0 = 1'b0; in1 = 1'b0;
        tick();
        rst = 1'b0;
        chk("sp_cnt_rst", 8'(glitch_cnt), 8'd0);
        in0 = 1'b1; in1 = 1'b1;
        tick(); tick(); tick();
        in1 = 1'b0;
        tick();
        chk("sp_glitch", 8'(glitch), 8'd1);
        chk("sp_cnt", 8'(glitch_cnt), 8'd1);
        chk("sp_out", 8'(out), 8'd0);
        tick();
        chk("sp_glitch_clr", 8'(glitch), 8'd0);

        // Saturation: five one-edge pulses -> 1,2,3,3,3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in1 = 1'b1;
            tick();
            chk("sat_pending", 8'(pending), 8'd1);
            in1 = 1'b0;
            tick();
            chk("sat_glitch", 8'(glitch), 8'd1);
            chk("sat_cnt", 8'(glitch_cnt), (i < 3) ? 8'(i + 1) : 8'd3);
            tick();
            chk("sat_glitch_clr", 8'(glitch), 8'd0);
        end

        // Reset at e0+2 aborts the candidate without counting it
        rst = 1'b1;
        tick();
        rst = 1'b0; in1 = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("mid_out", 8'(out), 8'd0);
        chk("mid_pending", 8'(pending), 8'd0);
        chk("mid_cnt", 8'(glitch_cnt), 8'd0);
        chk("mid_glitch", 8'(glitch), 8'd0);
        rst = 1'b0; in1 = 1'b0;
        tick();
        chk("mid_glitch_after", 8'(glitch), 8'd0);
        chk("mid_cnt_after", 8'(glitch_cnt), 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
